// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with configurable access latency.
// Stalls the core while an access is in flight and strobes done/addr_err on completion.
module dmem_responder #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic        memwrite,
   input  logic [31:0] dataaddr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        stall,
   output logic        done,
   output logic        addr_err
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    w_count_nxt;
   logic                w_accept;
   logic                w_complete;

   logic                r_we;
   logic                r_mis;
   logic [ADDR_W-1:0]   r_idx;
   logic [31:0]         r_wdata;
   logic [31:0]         r_rdata;
   logic [31:0]         r_rd_hold;

   logic [ADDR_W-1:0]   w_idx;
   logic                w_mis;
   logic [31:0]         w_rd_now;
   logic                w_unused_addr;

   logic [31:0]         mem [DEPTH];

   // Address bits above the RAM depth alias onto the same words.
   assign w_idx         = dataaddr[ADDR_W+1:2];
   assign w_mis         = |dataaddr[1:0];
   assign w_unused_addr = ^dataaddr[31:ADDR_W+2];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_accept    = 1'b0;
      w_complete  = 1'b0;
      stall       = 1'b0;
      case (r_state)
         S_IDLE: begin
            stall = ena & rst;
            if (ena) begin
               w_accept    = 1'b1;
               w_count_nxt = CNT_W'(LATENCY - 1);
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_count != '0) begin
               stall       = 1'b1;
               w_count_nxt = r_count - CNT_W'(1);
            end else begin
               w_complete  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Completion-cycle decodes; readdata shows the held value outside load completions.
   assign done     = w_complete;
   assign addr_err = w_complete & r_mis;
   assign w_rd_now = r_mis ? 32'd0 : r_rdata;
   assign readdata = (w_complete && !r_we) ? w_rd_now : r_rd_hold;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we      <= 1'b0;
         r_mis     <= 1'b0;
         r_idx     <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_rd_hold <= '0;
      end else begin
         if (w_accept) begin
            r_we    <= memwrite;
            r_mis   <= w_mis;
            r_idx   <= w_idx;
            r_wdata <= writedata;
            r_rdata <= mem[w_idx];
         end
         if (w_complete && !r_we) begin
            r_rd_hold <= w_rd_now;
         end
      end
   end

   // RAM contents survive reset; stores commit only at the completion edge.
   always_ff @(posedge clk) begin
      if (w_complete && r_we && !r_mis) begin
         mem[r_idx] <= r_wdata;
      end
   end

endmodule
